// File: rtl/output_interface_block.sv
// Packs SIZE_IN-bit symbols into SIZE_OUT-bit words, first symbol in the MSBs.
// Optional o_parity output enabled by defining OUTPUT_INTERFACE_PARITY_EN.
module output_interface_block #(
    parameter int unsigned SIZE_IN  = 2,
    parameter int unsigned SIZE_OUT = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_valid,
    input  logic [SIZE_IN-1:0]                   i_data,
    input  logic                                 i_last,
    output logic                                 o_ready,
    output logic                                 o_valid,
    output logic [SIZE_OUT-1:0]                  o_data,
    output logic [$clog2(SIZE_OUT/SIZE_IN):0]    o_count,
    output logic                                 o_last,
    input  logic                                 i_ready
`ifdef OUTPUT_INTERFACE_PARITY_EN
    ,
    output logic                                 o_parity
`endif
);

    localparam int unsigned NUM   = SIZE_OUT / SIZE_IN;
    localparam int unsigned CNT_W = $clog2(NUM) + 1;

    typedef enum logic {FILL, FULL} state_t;

    state_t              state_q, state_d;
    logic [SIZE_OUT-1:0] word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                last_q, last_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= FILL;
            word_q  <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            FILL: begin
                if (i_valid) begin
                    // Slot selected by the running count; slot 0 is the MSB field.
                    for (int unsigned k = 0; k < NUM; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            word_d[SIZE_OUT-1-k*SIZE_IN -: SIZE_IN] = i_data;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM - 1) || i_last) begin
                        state_d = FULL;
                        count_d = cnt_q + CNT_W'(1);
                        last_d  = i_last;
                    end
                end
            end
            FULL: begin
                if (i_ready) begin
                    state_d = FILL;
                    word_d  = '0;
                    cnt_d   = '0;
                    count_d = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign o_ready = (state_q == FILL);
    assign o_valid = (state_q == FULL);
    assign o_data  = word_q;
    assign o_count = count_q;
    assign o_last  = last_q;

`ifdef OUTPUT_INTERFACE_PARITY_EN
    logic parity_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^word_d;
        end
    end

    assign o_parity = parity_q;
`endif

endmodule

// File: tb/tb_output_interface_block.sv
// Self-checking bench for output_interface_block: directed vector table,
// hand-written backpressure/reset sequences and randomized model comparison.
module tb_output_interface_block;

    localparam int unsigned SIZE_IN  = 2;
    localparam int unsigned SIZE_OUT = 16;
    localparam int unsigned NUM      = SIZE_OUT / SIZE_IN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, last, ready;
    logic [1:0]  data;
    logic        o_ready, o_valid, o_last;
    logic [15:0] o_data;
    logic [3:0]  o_count;
`ifdef OUTPUT_INTERFACE_PARITY_EN
    logic        o_parity;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    output_interface_block #(.SIZE_IN(SIZE_IN), .SIZE_OUT(SIZE_OUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .i_data  (data),
        .i_last  (last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_count (o_count),
        .o_last  (o_last),
        .i_ready (ready)
`ifdef OUTPUT_INTERFACE_PARITY_EN
        ,
        .o_parity(o_parity)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: symbols collected so far for the current word.
    logic [1:0] m_sym[$];
    bit         m_full;
    bit         m_last;

    function automatic logic [15:0] m_word();
        logic [15:0] w = '0;
        foreach (m_sym[i]) w |= 16'(m_sym[i]) << (SIZE_OUT - SIZE_IN * (i + 1));
        return w;
    endfunction

    function automatic void model_reset();
        m_sym.delete();
        m_full = 1'b0;
        m_last = 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("valid", 32'(o_valid), 32'(m_full));
        check("ready", 32'(o_ready), 32'(!m_full));
        check("count", 32'(o_count), m_full ? 32'(m_sym.size()) : 32'd0);
        check("last",  32'(o_last),  32'(m_full & m_last));
        if (m_full) begin
            check("data", 32'(o_data), 32'(m_word()));
`ifdef OUTPUT_INTERFACE_PARITY_EN
            check("parity", 32'(o_parity), 32'(^m_word()));
`endif
        end
    endtask

    task automatic apply(input logic v, input logic [1:0] d, input logic l, input logic r);
        valid = v; data = d; last = l; ready = r;
        @(posedge clk);
        if (!m_full) begin
            if (v) begin
                m_sym.push_back(d);
                if (m_sym.size() == NUM || l) begin
                    m_full = 1'b1;
                    m_last = l;
                end
            end
        end else if (r) begin
            model_reset();
        end
        #1;
        check_model();
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        l;
        logic        r;
        bit          chk;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  ec;
        logic        el;
        logic        ep;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [1:0] d, logic l, logic r, bit chk,
                                logic ev, logic [15:0] ed, logic [3:0] ec, logic el, logic ep);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.r = r; e.chk = chk;
        e.ev = ev; e.ed = ed; e.ec = ec; e.el = el; e.ep = ep;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [1:0]  fw[8];
        logic [15:0] held;

        fw[0] = 2'b01; fw[1] = 2'b10; fw[2] = 2'b11; fw[3] = 2'b00;
        fw[4] = 2'b01; fw[5] = 2'b10; fw[6] = 2'b11; fw[7] = 2'b00;

        // Full word, then handshake
        for (int i = 0; i < 8; i++)
            add(1, fw[i], 0, 1, i == 7, 1, 16'h6C6C, 4'd8, 0, 0);
        add(0, 2'b00, 0, 1, 1, 0, 16'h0000, 4'd0, 0, 0);
        // Partial frame
        add(1, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 2'b10, 1, 1, 1, 1, 16'hD800, 4'd3, 1, 0);
        add(0, 2'b00, 0, 1, 1, 0, 16'h0000, 4'd0, 0, 0);
        // Input gaps carrying 11, also i_last without i_valid
        for (int i = 0; i < 8; i++) begin
            add(0, 2'b11, i == 3, 1, 0, 0, 0, 0, 0, 0);
            add(1, 2'b10, 0, 1, i == 7, 1, 16'hAAAA, 4'd8, 0, 0);
        end
        add(0, 2'b00, 0, 1, 1, 0, 16'h0000, 4'd0, 0, 0);
        // Last on the 8th symbol
        for (int i = 0; i < 8; i++)
            add(1, 2'b01, i == 7, 1, i == 7, 1, 16'h5555, 4'd8, 1, 0);
        add(0, 2'b00, 0, 1, 1, 0, 16'h0000, 4'd0, 0, 0);
        // Single symbol frame
        add(1, 2'b01, 1, 1, 1, 1, 16'h4000, 4'd1, 1, 1);
        add(0, 2'b00, 0, 1, 1, 0, 16'h0000, 4'd0, 0, 0);

        valid = 0; data = 0; last = 0; ready = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_last",  32'(o_last),  32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);

        foreach (tbl[i]) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].ev));
                check($sformatf("tbl%0d_data", i),  32'(o_data),  32'(tbl[i].ed));
                check($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].ec));
                check($sformatf("tbl%0d_last", i),  32'(o_last),  32'(tbl[i].el));
`ifdef OUTPUT_INTERFACE_PARITY_EN
                check($sformatf("tbl%0d_parity", i), 32'(o_parity), 32'(tbl[i].ep));
`endif
            end
        end

        // Backpressure: word held while other symbols are offered
        for (int i = 0; i < 8; i++) apply(1, 2'($urandom), 0, 0);
        held = m_word();
        for (int i = 0; i < 5; i++) begin
            apply(1, 2'($urandom), 0, 0);
            check("bp_data",  32'(o_data),  32'(held));
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
        end
        apply(1, 2'b11, 0, 1);
        check("bp_release_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 8; i++) apply(1, 2'b00, 0, 0);
        check("bp_next_data", 32'(o_data), 32'h0000);
        apply(0, 2'b00, 0, 1);

        // Asynchronous reset mid-word
        for (int i = 0; i < 4; i++) apply(1, 2'b10, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid", 32'(o_valid), 32'd0);
        check("mid_rst_data",  32'(o_data),  32'd0);
        check("mid_rst_count", 32'(o_count), 32'd0);
        check("mid_rst_last",  32'(o_last),  32'd0);
`ifdef OUTPUT_INTERFACE_PARITY_EN
        check("mid_rst_parity", 32'(o_parity), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 8; i++) apply(1, 2'b11, 0, 1);
        check("post_rst_data",  32'(o_data),  32'hFFFF);
        check("post_rst_count", 32'(o_count), 32'd8);
        apply(0, 2'b00, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++)
            apply($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/output_interface_block.md
# output_interface_block

Packs a stream of narrow decoded symbols into wide words for the Viterbi decoder's output side. It is the counterpart of the input interface, which splits a 16-bit word into 2-bit symbols, most-significant pair first. This block rebuilds the 16-bit word in the same order: the first symbol received lands in the MSBs. It sits between the decoder back-end and the downstream consumer, with valid/ready handshakes on both sides and explicit frame termination.

## Interface
- SIZE_IN, 2, symbol width in bits.
- SIZE_OUT, 16, packed word width in bits. Must be an integer multiple of SIZE_IN. NUM = SIZE_OUT/SIZE_IN (8 by default) is derived internally.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_valid  input  1  input symbol valid.
- i_data  input  SIZE_IN  symbol; ignored when i_valid=0.
- i_last  input  1  final symbol of the frame; qualified by i_valid.
- o_ready  output  1  block accepts a symbol this cycle.
- o_valid  output  1  packed word available.
- o_data  output  SIZE_OUT  packed word, first symbol at [SIZE_OUT-1 -: SIZE_IN].
- o_count  output  $clog2(NUM)+1  number of valid symbols in o_data (1..NUM).
- o_last  output  1  the word closes a frame.
- i_ready  input  1  consumer accepts the word.

## Operation
- Two states: FILL and FULL.
- **FILL**
  - o_ready=1, o_valid=0.
  - A symbol is accepted on a rising edge with i_valid=1.
  - The symbol is written to word[SIZE_OUT-1-cnt*SIZE_IN -: SIZE_IN], then cnt increments.
- **Transition FILL -> FULL** on the edge that accepts either:
  - the NUM-th symbol (cnt==NUM-1), or
  - any symbol with i_last=1.
  - On that edge, o_count loads cnt+1 and o_last loads i_last.
- **FULL**
  - o_valid=1, o_ready=0.
  - o_data, o_count and o_last hold stable until handshake.
- **Transition FULL -> FILL** on an edge with i_ready=1. On that edge: word cleared to 0, cnt=0, o_last=0, o_count=0.
- Partial words (i_last before NUM symbols):
  - unfilled low bits read 0;
  - the first symbol is still at the MSBs.
- i_last on the NUM-th symbol gives a full word with o_last=1 and o_count=NUM.
- i_ready while in FILL, and i_last with i_valid=0, have no effect.
- Gaps in i_valid during FILL: cnt and word hold.
- Reset values: state=FILL, o_valid=0, o_data=0, o_count=0, o_last=0, cnt=0. o_ready=1 once reset is released.
- Reset mid-word or mid-handshake: the partial word is discarded and no word is emitted.

## Timing
- o_ready and o_valid are decoded from the registered state only. There is no combinational path from any input to any output.
- Latency: o_valid rises in the cycle after the edge that accepted the completing symbol.
- Throughput: NUM accept cycles plus at least 1 FULL cycle per word. Sustained rate is NUM+1 cycles per word with i_valid and i_ready held high.
- o_ready is 0 for the whole FULL period, including the handshake cycle. The first symbol of the next word is accepted no earlier than the edge after the handshake edge.

## Configuration
- OUTPUT_INTERFACE_PARITY_EN
  - **Defined:** adds output port o_parity (1 bit) = XOR reduction of the packed word. It is registered on the same edge as o_data, holds through FULL, and resets to 0.
  - **Undefined:** the port does not exist and no parity logic is built. All other behaviour is identical.

## Test plan
- **Full word.** Send 8 symbols back-to-back, i_ready=1: 01,10,11,00,01,10,11,00.
  - o_valid=1 for one cycle, starting the cycle after the 8th accept.
  - o_data=16'h6C6C, o_count=8, o_last=0, o_parity=0 (with macro).
- **Partial frame.** Send symbols 11,01,10 with i_last on the third.
  - o_data=16'hD800, o_count=3, o_last=1.
  - After handshake, o_count=0 and o_last=0.
- **Backpressure.** Complete a word, then hold i_ready=0 for 5 cycles while driving i_valid=1 with other data.
  - o_valid stays 1 and o_ready stays 0.
  - o_data is unchanged and no input symbols are consumed.
  - The next word starts cleanly after i_ready=1.
- **Input gaps.** Interleave i_valid=0 cycles (data=11) between 8 valid symbols all equal to 10.
  - o_data=16'hAAAA, o_count=8.
  - Gap data never appears in the word.
- **Reset mid-word.** Accept 4 symbols, pulse i_rst_n low asynchronously (between edges).
  - All outputs go to 0 immediately, with o_ready=1 after release.
  - The next 8 symbols (all 11) give o_data=16'hFFFF with o_count=8; no stale bits.
- **Last on 8th symbol.** Send 8 symbols all 01, with i_last on the 8th.
  - o_data=16'h5555, o_count=8, o_last=1.
  - o_parity=0 (with macro). With a single 01 plus i_last: o_data=16'h4000, o_parity=1.
